// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: EX bypass selects, load-use detection,
// and a busy tracker for one fixed-latency multi-cycle unit with its RAW/WAW/structural stalls.
module hazard_forward_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned SCNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSRC*REG_AW-1:0]   rs_ex,
    input  logic [NSRC*REG_AW-1:0]   rs_id,
    input  logic [NSRC-1:0]          rs_used_id,
    input  logic [REG_AW-1:0]        rd_id,
    input  logic                     RegWrite_id,
    input  logic                     mc_req_id,
    input  logic [REG_AW-1:0]        rd_ex,
    input  logic                     MemRead_ex,
    input  logic                     mc_start,
    input  logic [REG_AW-1:0]        mc_rd,
    input  logic [REG_AW-1:0]        rd_mem,
    input  logic                     RegWrite_mem,
    input  logic [REG_AW-1:0]        rd_wb,
    input  logic                     RegWrite_wb,
    output logic [NSRC*2-1:0]        forward,
    output logic                     stall,
    output logic                     flush_ex,
    output logic                     mc_busy,
    output logic                     mc_done,
    output logic [REG_AW-1:0]        mc_rd_out,
    output logic                     mc_err,
    output logic [SCNT_W-1:0]        stall_cycles
);

    localparam int unsigned CNT_W = $clog2(MC_LAT + 1);
    localparam logic [1:0]  FWD_RF  = 2'b00;
    localparam logic [1:0]  FWD_WB  = 2'b01;
    localparam logic [1:0]  FWD_MEM = 2'b10;
    localparam logic [1:0]  FWD_MC  = 2'b11;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
    logic                mc_err_q, mc_err_d;
    logic [SCNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic                load_use;
    logic                mc_raw;
    logic                mc_waw;
    logic                mc_struct;
    logic                mc_haz_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pend_rd_q      <= '0;
            mc_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_rd_q      <= pend_rd_d;
            mc_err_q       <= mc_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // MC busy FSM: next state and completion outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        mc_err_d  = mc_err_q;
        mc_done   = 1'b0;
        mc_busy   = 1'b0;
        mc_rd_out = '0;
        case (state_q)
            IDLE: begin
                if (mc_start) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_W'(MC_LAT);
                    pend_rd_d = mc_rd;
                end
            end
            BUSY: begin
                mc_busy   = 1'b1;
                mc_rd_out = pend_rd_q;
                if (cnt_q == CNT_W'(1)) begin
                    mc_done = 1'b1;
                    if (mc_start) begin
                        cnt_d     = CNT_W'(MC_LAT);
                        pend_rd_d = mc_rd;
                    end else begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        pend_rd_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (mc_start) begin
                        mc_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-slot EX bypass select; r0 is never forwarded
    always_comb begin
        forward = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (RegWrite_mem && (rd_mem != '0) && (rd_mem == rs_ex[i*REG_AW +: REG_AW])) begin
                forward[i*2 +: 2] = FWD_MEM;
            end else if (RegWrite_wb && (rd_wb != '0) && (rd_wb == rs_ex[i*REG_AW +: REG_AW])) begin
                forward[i*2 +: 2] = FWD_WB;
            end else if (mc_done && (pend_rd_q != '0) && (pend_rd_q == rs_ex[i*REG_AW +: REG_AW])) begin
                forward[i*2 +: 2] = FWD_MC;
            end else begin
                forward[i*2 +: 2] = FWD_RF;
            end
        end
    end

    // Load-use and MC-unit hazards; the done cycle is covered by regfile write-through
    always_comb begin
        load_use  = 1'b0;
        mc_raw    = 1'b0;
        mc_haz_en = mc_busy && !mc_done;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (MemRead_ex && (rd_ex != '0) && rs_used_id[i] &&
                (rs_id[i*REG_AW +: REG_AW] == rd_ex)) begin
                load_use = 1'b1;
            end
            if (mc_haz_en && (pend_rd_q != '0) && rs_used_id[i] &&
                (rs_id[i*REG_AW +: REG_AW] == pend_rd_q)) begin
                mc_raw = 1'b1;
            end
        end
        mc_waw    = mc_haz_en && RegWrite_id && (rd_id != '0) && (rd_id == pend_rd_q);
        mc_struct = mc_haz_en && mc_req_id;
    end

    // Stall outputs and saturating stall-cycle counter
    always_comb begin
        stall          = load_use || mc_raw || mc_waw || mc_struct;
        flush_ex       = stall;
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + SCNT_W'(1);
        end
    end

    assign mc_err       = mc_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl (NSRC=2, MC_LAT=4, SCNT_W=4).
module tb_hazard_forward_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned NSRC   = 2;
    localparam int unsigned MC_LAT = 4;
    localparam int unsigned SCNT_W = 4;

    logic                   clk;
    logic                   rst_n;
    logic [NSRC*REG_AW-1:0] rs_ex;
    logic [NSRC*REG_AW-1:0] rs_id;
    logic [NSRC-1:0]        rs_used_id;
    logic [REG_AW-1:0]      rd_id;
    logic                   RegWrite_id;
    logic                   mc_req_id;
    logic [REG_AW-1:0]      rd_ex;
    logic                   MemRead_ex;
    logic                   mc_start;
    logic [REG_AW-1:0]      mc_rd;
    logic [REG_AW-1:0]      rd_mem;
    logic                   RegWrite_mem;
    logic [REG_AW-1:0]      rd_wb;
    logic                   RegWrite_wb;
    logic [NSRC*2-1:0]      forward;
    logic                   stall;
    logic                   flush_ex;
    logic                   mc_busy;
    logic                   mc_done;
    logic [REG_AW-1:0]      mc_rd_out;
    logic                   mc_err;
    logic [SCNT_W-1:0]      stall_cycles;

    int n_cmp;
    int n_err;

    hazard_forward_ctrl #(
        .REG_AW(REG_AW), .NSRC(NSRC), .MC_LAT(MC_LAT), .SCNT_W(SCNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_ex(rs_ex), .rs_id(rs_id), .rs_used_id(rs_used_id),
        .rd_id(rd_id), .RegWrite_id(RegWrite_id), .mc_req_id(mc_req_id),
        .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
        .mc_start(mc_start), .mc_rd(mc_rd),
        .rd_mem(rd_mem), .RegWrite_mem(RegWrite_mem),
        .rd_wb(rd_wb), .RegWrite_wb(RegWrite_wb),
        .forward(forward), .stall(stall), .flush_ex(flush_ex),
        .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd_out(mc_rd_out),
        .mc_err(mc_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_ex = '0; rs_id = '0; rs_used_id = '0;
        rd_id = '0; RegWrite_id = 1'b0; mc_req_id = 1'b0;
        rd_ex = '0; MemRead_ex = 1'b0;
        mc_start = 1'b0; mc_rd = '0;
        rd_mem = '0; RegWrite_mem = 1'b0;
        rd_wb = '0; RegWrite_wb = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("rst_stall", 32'(stall), 0);
        check("rst_busy", 32'(mc_busy), 0);
        check("rst_rd_out", 32'(mc_rd_out), 0);
        check("rst_scnt", 32'(stall_cycles), 0);
        rst_n = 1'b1;
        step();

        // Forwarding priority
        rs_ex = {5'd0, 5'd5};
        rd_mem = 5'd5; RegWrite_mem = 1'b1;
        rd_wb = 5'd5;  RegWrite_wb = 1'b1;
        #1 check("fwd_mem_prio", 32'(forward), 32'h2);
        RegWrite_mem = 1'b0;
        #1 check("fwd_wb", 32'(forward), 32'h1);
        rs_ex = {5'd5, 5'd3}; rd_mem = 5'd3; RegWrite_mem = 1'b1;
        #1 check("fwd_two_slots", 32'(forward), 32'h6);
        rs_ex = '0; rd_mem = '0; rd_wb = '0;
        #1 check("fwd_r0", 32'(forward), 32'h0);
        clear_inputs();

        // Load-use
        MemRead_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd7, 5'd0}; rs_used_id = 2'b10;
        #1 check("lu_stall", 32'(stall), 1);
        check("lu_flush", 32'(flush_ex), 1);
        step();
        MemRead_ex = 1'b0;
        #1 check("lu_one_cycle", 32'(stall), 0);
        check("lu_scnt", 32'(stall_cycles), 1);
        MemRead_ex = 1'b1; rs_used_id = 2'b01;
        #1 check("lu_unused_slot", 32'(stall), 0);
        clear_inputs();

        // MC RAW: start at cycle 0, done at cycle 4
        mc_start = 1'b1; mc_rd = 5'd9;
        #1 check("raw_c0_busy", 32'(mc_busy), 0);
        step();
        mc_start = 1'b0; rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            #1 check($sformatf("raw_c%0d_stall", c), 32'(stall), 1);
            check($sformatf("raw_c%0d_done", c), 32'(mc_done), 0);
            check($sformatf("raw_c%0d_rdout", c), 32'(mc_rd_out), 9);
            step();
        end
        rs_ex = {5'd0, 5'd9};
        #1 check("raw_c4_done", 32'(mc_done), 1);
        check("raw_c4_stall", 32'(stall), 0);
        check("raw_c4_fwd_mc", 32'(forward), 32'h3);
        step();
        #1 check("raw_c5_busy", 32'(mc_busy), 0);
        check("raw_c5_fwd", 32'(forward), 0);
        check("raw_c5_rdout", 32'(mc_rd_out), 0);
        clear_inputs();

        // Structural stall plus mc_start while busy
        mc_start = 1'b1; mc_rd = 5'd9;
        step();
        mc_start = 1'b0; mc_req_id = 1'b1;
        #1 check("st_c1_stall", 32'(stall), 1);
        step();
        mc_start = 1'b1; mc_rd = 5'd12;
        #1 check("st_c2_stall", 32'(stall), 1);
        check("st_c2_err_pre", 32'(mc_err), 0);
        step();
        mc_start = 1'b0;
        #1 check("st_c3_err", 32'(mc_err), 1);
        check("st_c3_rdout", 32'(mc_rd_out), 9);
        check("st_c3_stall", 32'(stall), 1);
        step();
        #1 check("st_c4_done", 32'(mc_done), 1);
        check("st_c4_stall", 32'(stall), 0);
        step();
        #1 check("st_c5_idle", 32'(mc_busy), 0);
        check("st_c5_done", 32'(mc_done), 0);
        clear_inputs();

        // WAW, then back-to-back issue in the done cycle
        mc_start = 1'b1; mc_rd = 5'd9;
        step();
        mc_start = 1'b0; RegWrite_id = 1'b1; rd_id = 5'd9;
        for (int c = 1; c <= 3; c++) begin
            #1 check($sformatf("waw_c%0d_stall", c), 32'(stall), 1);
            step();
        end
        mc_start = 1'b1; mc_rd = 5'd3;
        #1 check("waw_c4_done", 32'(mc_done), 1);
        check("waw_c4_stall", 32'(stall), 0);
        step();
        mc_start = 1'b0; RegWrite_id = 1'b0; rd_id = '0;
        #1 check("b2b_busy", 32'(mc_busy), 1);
        check("b2b_rdout", 32'(mc_rd_out), 3);
        check("b2b_c5_done", 32'(mc_done), 0);
        step();
        step();
        #1 check("b2b_c7_done", 32'(mc_done), 0);
        step();
        #1 check("b2b_c8_done", 32'(mc_done), 1);
        check("b2b_c8_rdout", 32'(mc_rd_out), 3);
        step();
        #1 check("b2b_idle", 32'(mc_busy), 0);
        check("err_sticky", 32'(mc_err), 1);
        clear_inputs();

        // Reset mid-BUSY aborts the op
        mc_start = 1'b1; mc_rd = 5'd9;
        step();
        mc_start = 1'b0; rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
        #1 check("rst_pre_stall", 32'(stall), 1);
        step();
        rst_n = 1'b0;
        #1 check("rstm_busy", 32'(mc_busy), 0);
        check("rstm_stall", 32'(stall), 0);
        check("rstm_flush", 32'(flush_ex), 0);
        check("rstm_rdout", 32'(mc_rd_out), 0);
        check("rstm_err", 32'(mc_err), 0);
        check("rstm_scnt", 32'(stall_cycles), 0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("rstm_nodone%0d", c), 32'(mc_done), 0);
        end
        clear_inputs();

        // Stall counter saturation
        MemRead_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd7, 5'd0}; rs_used_id = 2'b10;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 2) check("scnt_3", 32'(stall_cycles), 3);
        end
        check("scnt_sat", 32'(stall_cycles), 15);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
